// File: rtl/lane_readout_arbiter.sv
// Round-robin readout arbiter: picks one enabled, non-empty lane FIFO, streams
// its packet word by word into a registered output stage, then re-arbitrates.
// Optional stall watchdog compiled in with `define ARB_TIMEOUT_EN.
module lane_readout_arbiter #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          use_lane,
    input  logic [3:0]          lane_valid,
    input  logic [4*DATA_W-1:0] lane_data,
    input  logic [3:0]          lane_last,
    output logic [3:0]          lane_rd,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_lane,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                timeout_err
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              state_q, state_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [3:0]          gnt_mask_q, gnt_mask_d;
    logic [3:0]          cand;
    logic [1:0]          pick;
    logic [1:0]          idx;
    logic                pick_found;
    logic                pop;
    logic                pop_last;
    logic                stall_to;
    logic [DATA_W-1:0]   out_data_q;
    logic [1:0]          out_lane_q;
    logic                out_last_q;
    logic                out_valid_q;

    // Round-robin search of enabled, non-empty lanes starting at rr_ptr
    always_comb begin
        cand       = use_lane & lane_valid;
        pick       = rr_ptr_q;
        pick_found = 1'b0;
        idx        = rr_ptr_q;
        // Walk from the far end so the lane closest to rr_ptr wins
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr_q + 2'(k);
            if (cand[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    // Pop strobe for the granted lane; held off while the output stage is full
    always_comb begin
        pop     = 1'b0;
        lane_rd = 4'b0000;
        if (!reset && state_q == StGrant) begin
            pop = gnt_mask_q[gnt_q] & lane_valid[gnt_q] & (~out_valid_q | out_ready);
            lane_rd[gnt_q] = pop;
        end
    end

    assign pop_last = pop & lane_last[gnt_q];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    // Stall watchdog: counts GRANT cycles with an empty granted lane
    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        timeout_err_d = timeout_err_q;
        stall_to      = 1'b0;
        if (state_q != StGrant || pop) begin
            stall_cnt_d = '0;
        end else if (!lane_valid[gnt_q]) begin
            if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                stall_to      = 1'b1;
                timeout_err_d = 1'b1;
                stall_cnt_d   = '0;
            end else begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Watchdog state; the error flag is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign stall_to    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state: grant in IDLE, release after the last word or a timeout
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        gnt_mask_d = gnt_mask_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gnt_d      = pick;
                    gnt_mask_d = use_lane;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (pop_last || stall_to) begin
                    state_d  = StIdle;
                    rr_ptr_d = gnt_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and arbitration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rr_ptr_q   <= 2'd0;
            gnt_q      <= 2'd0;
            gnt_mask_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            gnt_mask_q <= gnt_mask_d;
        end
    end

    // Output stage: load on pop, drain on accept, hold under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_lane_q  <= 2'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_data_q  <= lane_data[DATA_W*gnt_q +: DATA_W];
            out_lane_q  <= gnt_q;
            out_last_q  <= lane_last[gnt_q];
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == StGrant) & ~reset;

endmodule

// File: tb/tb_lane_readout_arbiter.sv
// Bench for lane_readout_arbiter: lane FIFOs modelled as queues, expected
// output stream predicted at packet level from the round-robin rules.
// The watchdog scenario is only built when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_lane_readout_arbiter;

    localparam int DW = 16;

    typedef logic [DW:0]   fword_t;   // {last, data}
    typedef logic [DW+2:0] beat_t;    // {lane, last, data}

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      use_lane = 4'b0000;
    logic [3:0]      lane_valid = 4'b0000;
    logic [4*DW-1:0] lane_data = '0;
    logic [3:0]      lane_last = 4'b0000;
    logic            out_ready = 1'b1;
    logic [3:0]      lane_rd;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_lane;
    logic            out_last;
    logic            out_valid;
    logic            busy;
    logic            timeout_err;

    fword_t fifo[4][$];
    beat_t  exp_q[$];
    beat_t  seen_q[$];
    int     seen_cyc[$];
    beat_t  cur_beat;
    int     n_tests = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     pops = 0;
    int     model_rr = 0;

    lane_readout_arbiter #(
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .use_lane   (use_lane),
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .lane_last  (lane_last),
        .lane_rd    (lane_rd),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present each queue head to the DUT as a show-ahead FIFO
    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (fifo[i].size() > 0) begin
                lane_valid[i]        = 1'b1;
                lane_data[i*DW +: DW] = fifo[i][0][DW-1:0];
                lane_last[i]         = fifo[i][0][DW];
            end else begin
                lane_valid[i]        = 1'b0;
                lane_data[i*DW +: DW] = '0;
                lane_last[i]         = 1'b0;
            end
        end
    endtask

    // One clock: sample pop strobes mid-cycle, apply them after the edge
    task automatic tick(input bit rand_ready);
        logic [3:0] rd;
        @(negedge clk);
        rd = lane_rd;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rd[i] && fifo[i].size() > 0) begin
                void'(fifo[i].pop_front());
                pops++;
            end
        end
        if (rand_ready) out_ready = 1'($urandom_range(1));
        drive();
    endtask

    task automatic load(input int lane, input logic [DW-1:0] base, input int n);
        for (int j = 0; j < n; j++) fifo[lane].push_back({j == n - 1, base + DW'(j)});
    endtask

    // Packet-level model: serve whole packets round-robin from model_rr
    task automatic predict(input logic [3:0] use_m);
        fword_t q[4][$];
        fword_t f;
        int     l;
        for (int i = 0; i < 4; i++) q[i] = fifo[i];
        while (1) begin
            l = -1;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (model_rr + k) % 4;
                if (l < 0 && use_m[c] && q[c].size() > 0) l = c;
            end
            if (l < 0) break;
            while (q[l].size() > 0) begin
                f = q[l].pop_front();
                exp_q.push_back({2'(l), f});
                if (f[DW]) break;
            end
            model_rr = (l + 1) % 4;
        end
    endtask

    task automatic run_until_empty(input string name, input int budget, input bit rr);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || out_valid) && n < budget) begin
            tick(rr);
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        out_ready = 1'b1;
    endtask

    // Compare process: every accepted beat against the model, plus pop rules
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (out_valid && out_ready) begin
                cur_beat = {out_lane, out_last, out_data};
                seen_q.push_back(cur_beat);
                seen_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat_extra: got %0h expected none", cur_beat);
                end else begin
                    chk("beat", cur_beat, exp_q.pop_front());
                end
            end
            chk("rd_onehot", $countones(lane_rd) <= 1, 1);
            chk("rd_on_empty", |(lane_rd & ~lane_valid), 0);
            chk("rd_under_backpressure", (|lane_rd) && out_valid && !out_ready, 0);
        end
    end

    initial begin
        int b;
        int n;
        int bad;

        drive();
        repeat (2) tick(0);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_lane", out_lane, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lane_rd", lane_rd, 0);
        chk("rst_timeout_err", timeout_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Two 3-word packets on lanes 0 and 2
        model_rr = 0;
        load(0, 16'hA0, 3);
        load(2, 16'hC0, 3);
        use_lane = 4'b0101;
        predict(use_lane);
        drive();
        b = seen_q.size();
        run_until_empty("two_pkts", 60, 0);
        chk("two_pkts_w2", seen_q[b+2], {2'd0, 1'b1, 16'hA2});
        chk("two_pkts_l2w0", seen_q[b+3], {2'd2, 1'b0, 16'hC0});
        chk("two_pkts_burst", seen_cyc[b+2] - seen_cyc[b], 2);
        chk("two_pkts_gap", seen_cyc[b+3] - seen_cyc[b+2], 2);

        // No lanes enabled: nothing may move
        use_lane = 4'b0000;
        for (int i = 0; i < 4; i++) load(i, 16'h50 + DW'(i), 1);
        drive();
        bad = 0;
        repeat (100) begin
            tick(0);
            if (lane_rd !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("no_enable_idle", bad, 0);
        for (int i = 0; i < 4; i++) fifo[i].delete();
        drive();

        // Enable mask changes mid-packet: lane1 completes, then lane3
        load(1, 16'h10, 4);
        load(3, 16'h30, 2);
        use_lane = 4'b0010;
        for (int j = 0; j < 4; j++) exp_q.push_back({2'd1, j == 3, 16'h10 + DW'(j)});
        for (int j = 0; j < 2; j++) exp_q.push_back({2'd3, j == 1, 16'h30 + DW'(j)});
        drive();
        b = seen_q.size();
        n = 0;
        while ((exp_q.size() > 0 || out_valid) && n < 60) begin
            tick(0);
            if (fifo[1].size() == 2) use_lane = 4'b1000;
            n++;
        end
        chk("mask_change_drained", exp_q.size(), 0);
        chk("mask_change_next_lane", seen_q[b+4][DW+2:DW+1], 3);
        model_rr = 0;

        // 16-word packet under random backpressure
        load(0, 16'h100, 16);
        use_lane = 4'b0001;
        predict(use_lane);
        pops = 0;
        b = seen_q.size();
        drive();
        run_until_empty("backpressure", 400, 1);
        chk("backpressure_pops", pops, 16);
        chk("backpressure_beats", seen_q.size() - b, 16);

        // All lanes busy: rotation continues from lane 1
        for (int i = 0; i < 4; i++) load(i, 16'h200 + DW'(16 * i), 2);
        use_lane = 4'b1111;
        predict(use_lane);
        drive();
        b = seen_q.size();
        run_until_empty("rotate", 80, 0);
        chk("rotate_first", seen_q[b][DW+2:DW+1], 1);
        chk("rotate_third", seen_q[b+4][DW+2:DW+1], 3);
        chk("rotate_last", seen_q[b+6][DW+2:DW+1], 0);

        // Reset in the middle of a lane2 packet
        load(2, 16'h300, 4);
        use_lane = 4'b0100;
        predict(use_lane);
        drive();
        n = 0;
        while (fifo[2].size() > 2 && n < 40) begin
            tick(0);
            n++;
        end
        chk("mid_reset_reached", fifo[2].size(), 2);
        reset = 1'b1;
        exp_q.delete();
        tick(0);
        reset = 1'b0;
        fifo[2].delete();
        drive();
        chk("mid_reset_out_valid", out_valid, 0);
        chk("mid_reset_lane_rd", lane_rd, 0);
        chk("mid_reset_busy", busy, 0);
        model_rr = 0;
        load(0, 16'h400, 1);
        load(1, 16'h410, 1);
        use_lane = 4'b0011;
        predict(use_lane);
        drive();
        b = seen_q.size();
        run_until_empty("post_reset", 40, 0);
        chk("post_reset_rr", seen_q[b][DW+2:DW+1], 0);

`ifdef ARB_TIMEOUT_EN
        // Lane0 runs dry mid-packet: watchdog must release the grant
        model_rr = 0;
        fifo[0].push_back({1'b0, 16'h500});
        fifo[0].push_back({1'b0, 16'h501});
        exp_q.push_back({2'd0, 1'b0, 16'h500});
        exp_q.push_back({2'd0, 1'b0, 16'h501});
        use_lane = 4'b0001;
        drive();
        n = 0;
        while (!timeout_err && n < 60) begin
            tick(0);
            n++;
        end
        chk("timeout_err_set", timeout_err, 1);
        tick(0);
        chk("timeout_idle", busy, 0);
        chk("timeout_words", exp_q.size(), 0);
        model_rr = 1;
        load(0, 16'h600, 1);
        load(1, 16'h610, 1);
        use_lane = 4'b0011;
        predict(use_lane);
        drive();
        b = seen_q.size();
        run_until_empty("timeout_rr", 40, 0);
        chk("timeout_rr_next", seen_q[b][DW+2:DW+1], 1);
        chk("timeout_err_sticky", timeout_err, 1);
        reset = 1'b1;
        tick(0);
        reset = 1'b0;
        chk("timeout_err_cleared", timeout_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_readout_arbiter.md
LANE_READOUT_ARBITER -- requirements
Module: lane_readout_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of one lane data word.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: stall limit used only when ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state SHALL change on the rising edge of clk only.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 use_lane  input  4  lane enable mask from the lane-select stage; bit i enables lane i.
REQ-007 lane_valid  input  4  per-lane show-ahead FIFO not-empty flag.
REQ-008 lane_data  input  4*DATA_W  per-lane head word; lane i occupies [DATA_W*i+DATA_W-1 : DATA_W*i].
REQ-009 lane_last  input  4  per-lane flag: the head word is the last word of its packet.
REQ-010 lane_rd  output  4  one-hot FIFO pop strobe, combinational.
REQ-011 out_data  output  DATA_W  registered output word.
REQ-012 out_lane  output  2  source lane index of out_data.
REQ-013 out_last  output  1  out_data is the end of a packet.
REQ-014 out_valid  output  1  output word is valid.
REQ-015 out_ready  input  1  downstream accepts the word when out_valid=1 and out_ready=1.
REQ-016 busy  output  1  high while the FSM is in GRANT.
REQ-017 timeout_err  output  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have two states: IDLE and GRANT.
REQ-019 In IDLE, the block SHALL form cand = use_lane & lane_valid and search cand round-robin, starting at the lane index held in rr_ptr and wrapping 3->0.
REQ-020 If cand is nonzero, the block SHALL latch the first matching lane into gnt and gnt_mask = use_lane, then enter GRANT on the next edge.
REQ-021 If cand is zero, including use_lane=0, the FSM SHALL stay in IDLE and lane_rd SHALL be 0.
REQ-022 In GRANT, lane_rd[gnt] SHALL be driven as lane_valid[gnt] & (~out_valid | out_ready); all other lane_rd bits SHALL be 0.
REQ-023 On any cycle with lane_rd[gnt]=1, the output register SHALL load out_data=lane word gnt, out_lane=gnt, out_last=lane_last[gnt] and set out_valid=1. Latency SHALL be 1 cycle from pop to out_valid.
REQ-024 When out_valid=1, out_ready=1 and no pop occurs in the same cycle, out_valid SHALL clear.
REQ-025 When out_valid=1, out_ready=0, the output register SHALL hold all fields unchanged; no pop SHALL occur.
REQ-026 When a word with lane_last=1 is popped, the FSM SHALL return to IDLE on the next edge and set rr_ptr=(gnt+1) mod 4.
REQ-027 Changes to use_lane while in GRANT SHALL be ignored until IDLE; a packet that has started SHALL always complete.
REQ-028 Sustained throughput SHALL be 1 word/cycle while lane_valid[gnt]=1 and out_ready=1.
REQ-029 Each packet SHALL incur one IDLE cycle of arbitration overhead.

Reset
REQ-030 While reset=1, the block SHALL force state=IDLE, rr_ptr=0, gnt=0, out_valid=0, out_data=0, out_lane=0, out_last=0, busy=0, timeout_err=0 and lane_rd=0.
REQ-031 A reset asserted mid-packet SHALL discard any partially forwarded packet without emitting an out_last.

Configuration
REQ-032 The macro ARB_TIMEOUT_EN SHALL compile the stall watchdog in or out.
REQ-033 With ARB_TIMEOUT_EN defined, a counter SHALL increment each GRANT cycle with lane_valid[gnt]=0 and clear on every pop and in IDLE.
REQ-034 With ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 the block SHALL set timeout_err=1 (cleared only by reset), return to IDLE and advance rr_ptr as in REQ-026.
REQ-035 Without ARB_TIMEOUT_EN, timeout_err SHALL be tied to 0 and GRANT SHALL wait indefinitely.

Verification
REQ-036 use_lane=4'b0101, lanes 0 and 2 each hold a 3-word packet, out_ready=1 -> output sequence lane0 w0..w2 with out_last on w2, one gap cycle, then lane2 w0..w2.
REQ-037 use_lane=0, all lane_valid=1 -> lane_rd stays 0 and out_valid stays 0 for 100 cycles.
REQ-038 During a lane1 packet, use_lane switches 4'b0010->4'b1000 after word 1 -> lane1 packet completes, next grant goes to lane3.
REQ-039 Random out_ready backpressure at 50% on a 16-word packet -> all 16 words delivered in order, no word lost or duplicated, lane_rd count=16.
REQ-040 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, lane0 stalls after word 1 -> timeout_err=1 after 8 stall cycles, FSM in IDLE, rr_ptr=1; reset clears timeout_err.
REQ-041 Reset asserted during word 2 of a lane2 packet -> next cycle out_valid=0, lane_rd=0, busy=0, rr_ptr=0.
